lsq_mem_issue: RTL and testbench

- In-order load/store issue queue that sits directly upstream of the byte-addressed data RAM.
- Accepts memory ops from the load/store reservation stations and computes effective addresses.
- Drives the RAM's active-low read/write strobes one op at a time.
- Broadcasts load results on the CDB with their tag and signals store completion to the ROB/RS logic.

---
 rtl/lsq_mem_issue.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsq_mem_issue.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_mem_issue.sv
// lsq_mem_issue: in-order load/store issue queue in front of the byte-addressed data RAM.
// Ops from the reservation stations are queued with their effective address (base + offset).
// They are then issued to the RAM one at a time. Load results go out on the CDB, and each
// completed store produces a one-cycle st_done pulse.
//
// Optional feature macro: MEM_CHECK_EN.
//   When defined, misaligned or out-of-range ops are never sent to the RAM.
//   Each such op is retired with a one-cycle err/err_tag pulse.
//   The err and err_tag ports exist only in this build.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    op handshake; in_ready = queue not full
//   in_is_store, in_tag  op kind and producer tag
//   in_base, in_offset   address operands; EA = base + offset (mod 2^32)
//   in_data              store data
//   mem_addr, mem_wdata  RAM address and big-endian write data
//   mem_nRD, mem_nWR     active-low strobes, low only in the ACCESS cycle
//   mem_rdata            RAM read data
//   cdb_valid/tag/data   load broadcast, held stable until cdb_grant
//   cdb_grant            arbiter accepts the broadcast
//   st_done, st_tag      store completion pulse
//   err, err_tag         rejected-op pulse (MEM_CHECK_EN only)
module lsq_mem_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MEM_TOP = 57
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_store,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_offset,
    input  logic [31:0]      in_data,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_nRD,
    output logic             mem_nWR,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    input  logic             cdb_grant,
    output logic             st_done,
    output logic [TAG_W-1:0] st_tag
`ifdef MEM_CHECK_EN
    ,
    output logic             err,
    output logic [TAG_W-1:0] err_tag
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MEM_TOP < 3) begin : g_bad_params
        $error("lsq_mem_issue: DEPTH must be a power of 2 >= 2 and MEM_TOP >= 3");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, BCAST} state_t;

    state_t state, state_nxt;

    logic [31:0]      q_ea   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [TAG_W-1:0] q_tag  [DEPTH];
    logic             q_st   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic push_c, pop_c, not_empty_c, access_bad_c;
    logic [31:0]      head_ea, head_data;
    logic [TAG_W-1:0] head_tag;
    logic             head_st;

    logic [31:0]      mem_addr_nxt, mem_wdata_nxt, cdb_data_nxt;
    logic             mem_nrd_nxt, mem_nwr_nxt, cdb_valid_nxt, st_done_nxt;
    logic [TAG_W-1:0] cdb_tag_nxt, st_tag_nxt;

    assign in_ready    = (count != CNT_W'(DEPTH));
    assign push_c      = in_valid && in_ready;
    assign not_empty_c = (count != CNT_W'(0));
    assign head_ea     = q_ea[rd_ptr];
    assign head_data   = q_data[rd_ptr];
    assign head_tag    = q_tag[rd_ptr];
    assign head_st     = q_st[rd_ptr];

`ifdef MEM_CHECK_EN
    logic             head_bad_c, bad_q, bad_nxt, err_nxt;
    logic [TAG_W-1:0] err_tag_nxt;

    assign head_bad_c   = (head_ea[1:0] != 2'b00) || (head_ea > 32'(MEM_TOP));
    assign access_bad_c = bad_q;
`else
    assign access_bad_c = 1'b0;
`endif

    // Queue payload; only pointers and count are reset, so a flush just empties the ring
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_ea[wr_ptr]   <= in_base + in_offset;
            q_data[wr_ptr] <= in_data;
            q_tag[wr_ptr]  <= in_tag;
            q_st[wr_ptr]   <= in_is_store;
        end
    end

    // Ring pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (not_empty_c) state_nxt = ACCESS;
            ACCESS:  state_nxt = (head_st || access_bad_c) ? IDLE : BCAST;
            BCAST:   if (cdb_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / pop logic: next values for the registered outputs
    always_comb begin
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_nrd_nxt   = 1'b1;
        mem_nwr_nxt   = 1'b1;
        cdb_valid_nxt = cdb_valid;
        cdb_tag_nxt   = cdb_tag;
        cdb_data_nxt  = cdb_data;
        st_done_nxt   = 1'b0;
        st_tag_nxt    = st_tag;
        pop_c         = 1'b0;
`ifdef MEM_CHECK_EN
        bad_nxt       = bad_q;
        err_nxt       = 1'b0;
        err_tag_nxt   = err_tag;
`endif
        case (state)
            IDLE: begin
                if (not_empty_c) begin
                    mem_addr_nxt = head_ea;
`ifdef MEM_CHECK_EN
                    bad_nxt = head_bad_c;
                    if (!head_bad_c) begin
`else
                    begin
`endif
                        if (head_st) begin
                            mem_wdata_nxt = head_data;
                            mem_nwr_nxt   = 1'b0;
                        end else begin
                            mem_nrd_nxt   = 1'b0;
                        end
                    end
                end
            end
            ACCESS: begin
                if (access_bad_c) begin
                    pop_c = 1'b1;
`ifdef MEM_CHECK_EN
                    err_nxt     = 1'b1;
                    err_tag_nxt = head_tag;
`endif
                end else if (head_st) begin
                    pop_c       = 1'b1;
                    st_done_nxt = 1'b1;
                    st_tag_nxt  = head_tag;
                end else begin
                    cdb_valid_nxt = 1'b1;
                    cdb_tag_nxt   = head_tag;
                    cdb_data_nxt  = mem_rdata;
                end
            end
            BCAST: begin
                if (cdb_grant) begin
                    pop_c         = 1'b1;
                    cdb_valid_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_nRD   <= 1'b1;
            mem_nWR   <= 1'b1;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            st_done   <= 1'b0;
            st_tag    <= '0;
`ifdef MEM_CHECK_EN
            bad_q     <= 1'b0;
            err       <= 1'b0;
            err_tag   <= '0;
`endif
        end else begin
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_nRD   <= mem_nrd_nxt;
            mem_nWR   <= mem_nwr_nxt;
            cdb_valid <= cdb_valid_nxt;
            cdb_tag   <= cdb_tag_nxt;
            cdb_data  <= cdb_data_nxt;
            st_done   <= st_done_nxt;
            st_tag    <= st_tag_nxt;
`ifdef MEM_CHECK_EN
            bad_q     <= bad_nxt;
            err       <= err_nxt;
            err_tag   <= err_tag_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lsq_mem_issue.sv
// Self-checking bench for lsq_mem_issue.
// The model is an in-order list of accepted ops plus a byte-array image of the RAM.
// Each completion is retired in program order against that image.
module tb_lsq_mem_issue;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [1:0] K_LOAD = 2'd0, K_STORE = 2'd1, K_ERR = 2'd2, K_NONE = 2'd3;

    typedef struct packed {
        logic        is_store;
        logic [3:0]  tag;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] data;
    } stim_t;

    typedef struct packed {
        logic        is_store;
        logic [3:0]  tag;
        logic [31:0] ea;
        logic [31:0] data;
    } op_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  tag;
        logic [31:0] data;
    } rec_t;

    logic             clk, rst;
    logic             in_valid, in_ready, in_is_store;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_base, in_offset, in_data;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic             mem_nRD, mem_nWR;
    logic             cdb_valid, cdb_grant, st_done;
    logic [TAG_W-1:0] cdb_tag, st_tag;
    logic [31:0]      cdb_data;
`ifdef MEM_CHECK_EN
    logic             err;
    logic [TAG_W-1:0] err_tag;
`endif

    lsq_mem_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MEM_TOP(57)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_tag(in_tag), .in_base(in_base), .in_offset(in_offset), .in_data(in_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_nRD(mem_nRD), .mem_nWR(mem_nWR),
        .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
        .st_done(st_done), .st_tag(st_tag)
`ifdef MEM_CHECK_EN
        , .err(err), .err_tag(err_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: writes on negedge while nWR is low, big-endian read
    logic [7:0] ram     [64];
    logic [7:0] ref_ram [64];
    logic [5:0] ra;
    assign ra = mem_addr[5:0];
    assign mem_rdata = {ram[ra], ram[ra + 6'd1], ram[ra + 6'd2], ram[ra + 6'd3]};
    always @(negedge clk) begin
        if (!mem_nWR) begin
            ram[ra]        = mem_wdata[31:24];
            ram[ra + 6'd1] = mem_wdata[23:16];
            ram[ra + 6'd2] = mem_wdata[15:8];
            ram[ra + 6'd3] = mem_wdata[7:0];
        end
    end

    int n_cmp = 0, n_fail = 0;
    int acc_cnt = 0, occ = 0, strobe_cnt = 0, both_low = 0;
    op_t  cur_op;
    op_t  pend_q[$];
    rec_t obs_q[$];
    logic [31:0] strobe_addr_q[$];

    // Reference: retire the oldest accepted op against the RAM image
    function automatic rec_t model_retire();
        op_t  o;
        rec_t r;
        int   a;
        r = '{kind: K_NONE, tag: 4'h0, data: 32'h0};
        if (pend_q.size() == 0) return r;
        o = pend_q.pop_front();
        a = int'(o.ea[5:0]);
`ifdef MEM_CHECK_EN
        if (o.ea[1:0] != 2'b00 || o.ea > 32'd57) begin
            r = '{kind: K_ERR, tag: o.tag, data: 32'h0};
            return r;
        end
`endif
        if (o.is_store) begin
            ref_ram[a]          = o.data[31:24];
            ref_ram[(a + 1) % 64] = o.data[23:16];
            ref_ram[(a + 2) % 64] = o.data[15:8];
            ref_ram[(a + 3) % 64] = o.data[7:0];
            r = '{kind: K_STORE, tag: o.tag, data: 32'h0};
        end else begin
            r = '{kind: K_LOAD, tag: o.tag,
                  data: {ref_ram[a], ref_ram[(a + 1) % 64], ref_ram[(a + 2) % 64], ref_ram[(a + 3) % 64]}};
        end
        return r;
    endfunction

    function automatic stim_t gen_stim(input logic st);
        stim_t       s;
        logic [31:0] ea;
        ea         = 32'($urandom_range(0, 14)) << 2;
        s.is_store = st;
        s.tag      = 4'($urandom);
        s.base     = $urandom;
        s.off      = ea - s.base;
        s.data     = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        in_valid    = 1'b1;
        in_is_store = s.is_store;
        in_tag      = s.tag;
        in_base     = s.base;
        in_offset   = s.off;
        in_data     = s.data;
        cur_op      = '{is_store: s.is_store, tag: s.tag, ea: s.base + s.off, data: s.data};
    endtask

    // One clock; logs handshakes and completions seen at this edge
    task automatic step();
        logic        pa, pg;
        logic [3:0]  gt;
        logic [31:0] gd;
        rec_t        r;
        pa = in_valid && in_ready && !rst;
        pg = cdb_valid && cdb_grant && !rst;
        gt = cdb_tag;
        gd = cdb_data;
        @(posedge clk);
        #1;
        if (pa) begin pend_q.push_back(cur_op); acc_cnt++; occ++; end
        if (pg) begin r = '{kind: K_LOAD, tag: gt, data: gd}; obs_q.push_back(r); occ--; end
        if (st_done) begin r = '{kind: K_STORE, tag: st_tag, data: 32'h0}; obs_q.push_back(r); occ--; end
`ifdef MEM_CHECK_EN
        if (err) begin r = '{kind: K_ERR, tag: err_tag, data: 32'h0}; obs_q.push_back(r); occ--; end
`endif
        if (!mem_nRD || !mem_nWR) begin strobe_cnt++; strobe_addr_q.push_back(mem_addr); end
        if (!mem_nRD && !mem_nWR) both_low++;
    endtask

    task automatic offer(input stim_t s);
        int a0;
        a0 = acc_cnt;
        drive(s);
        for (int i = 0; i < 50 && acc_cnt == a0; i++) step();
        in_valid = 1'b0;
        if (acc_cnt == a0) begin
            n_cmp++; n_fail++;
            $display("FAIL offer_timeout: op tag %0h not accepted within 50 cycles", s.tag);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && obs_q.size() < pend_q.size(); i++) step();
        if (obs_q.size() < pend_q.size()) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d completions seen, %0d required", obs_q.size(), pend_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp += 10;
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (mem_nRD !== 1'b1)    begin n_fail++; $display("FAIL rst_nrd: got %b want 1", mem_nRD); end
        if (mem_nWR !== 1'b1)    begin n_fail++; $display("FAIL rst_nwr: got %b want 1", mem_nWR); end
        if (mem_addr !== 32'h0)  begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        if (cdb_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_cdb_valid: got %b want 0", cdb_valid); end
        if (cdb_tag !== 4'h0)    begin n_fail++; $display("FAIL rst_cdb_tag: got %h want 0", cdb_tag); end
        if (cdb_data !== 32'h0)  begin n_fail++; $display("FAIL rst_cdb_data: got %h want 0", cdb_data); end
        if (st_done !== 1'b0)    begin n_fail++; $display("FAIL rst_st_done: got %b want 0", st_done); end
        if (st_tag !== 4'h0)     begin n_fail++; $display("FAIL rst_st_tag: got %h want 0", st_tag); end
`ifdef MEM_CHECK_EN
        n_cmp += 2;
        if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        if (err_tag !== 4'h0)    begin n_fail++; $display("FAIL rst_err_tag: got %h want 0", err_tag); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        rec_t o, e;
        cdb_grant = 1'b1;
        offer('{is_store: 1'b1, tag: 4'd3, base: 32'd4, off: 32'd4, data: 32'hA1B2C3D4});
        drive('{is_store: 1'b0, tag: 4'd5, base: 32'd8, off: 32'd0, data: 32'h0});
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({mem_nWR, mem_nRD, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'd8, 32'hA1B2C3D4}) begin
            n_fail++;
            $display("FAIL sl_store_access: got nWR=%b nRD=%b addr=%h wdata=%h want 0 1 00000008 a1b2c3d4",
                     mem_nWR, mem_nRD, mem_addr, mem_wdata);
        end
        step();
        n_cmp++;
        if ({st_done, st_tag, mem_nWR} !== {1'b1, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL sl_st_done: got st_done=%b tag=%h nWR=%b want 1 3 1", st_done, st_tag, mem_nWR);
        end
        drain();
        n_cmp++;
        if ({ram[8], ram[9], ram[10], ram[11]} !== 32'hA1B2C3D4) begin
            n_fail++;
            $display("FAIL sl_ram_bytes: got %h want a1b2c3d4", {ram[8], ram[9], ram[10], ram[11]});
        end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[1] !== '{kind: K_LOAD, tag: 4'd5, data: 32'hA1B2C3D4}) begin
            n_fail++;
            $display("FAIL sl_load_result: %0d completions, last=%h want load tag 5 data a1b2c3d4",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0);
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sl_order: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
    endtask

    task automatic test_grant_stall();
        stim_t       s;
        rec_t        o, e;
        logic [3:0]  t0;
        logic [31:0] d0;
        cdb_grant = 1'b0;
        s = gen_stim(1'b0);
        offer(s);
        step();
        n_cmp++;
        if (mem_nRD !== 1'b0 || mem_addr !== s.base + s.off) begin
            n_fail++;
            $display("FAIL gs_load_access: got nRD=%b addr=%h want 0 %h", mem_nRD, mem_addr, s.base + s.off);
        end
        step();
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== s.tag) begin
            n_fail++;
            $display("FAIL gs_cdb_start: got valid=%b tag=%h want 1 %h", cdb_valid, cdb_tag, s.tag);
        end
        t0 = cdb_tag;
        d0 = cdb_data;
        drive(gen_stim(1'b1));
        for (int i = 0; i < 5; i++) begin
            step();
            in_valid = 1'b0;
            n_cmp++;
            if ({cdb_valid, cdb_tag, cdb_data, mem_nRD, mem_nWR} !== {1'b1, t0, d0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL gs_hold_%0d: got valid=%b tag=%h data=%h nRD=%b nWR=%b want 1 %h %h 1 1",
                         i, cdb_valid, cdb_tag, cdb_data, mem_nRD, mem_nWR, t0, d0);
            end
        end
        cdb_grant = 1'b1;
        step();
        n_cmp++;
        if ({cdb_valid, mem_nRD, mem_nWR} !== 3'b011) begin
            n_fail++;
            $display("FAIL gs_release: got valid=%b nRD=%b nWR=%b want 0 1 1", cdb_valid, mem_nRD, mem_nWR);
        end
        drain();
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL gs_order: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
    endtask

    task automatic test_full();
        stim_t ops[6];
        rec_t  o, e;
        int    idx, a0, base_acc;
        cdb_grant = 1'b0;
        ops[0] = gen_stim(1'b0);
        for (int i = 1; i < 6; i++) ops[i] = gen_stim(1'($urandom_range(0, 1)));
        idx = 0;
        base_acc = acc_cnt;
        drive(ops[0]);
        for (int c = 0; c < 10; c++) begin
            a0 = acc_cnt;
            step();
            if (acc_cnt != a0) begin
                idx++;
                if (idx < 6) drive(ops[idx]); else in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (acc_cnt - base_acc != 4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: accepted=%0d in_ready=%b want 4 0", acc_cnt - base_acc, in_ready);
        end
        cdb_grant = 1'b1;
        for (int c = 0; c < 80 && !(idx == 6 && obs_q.size() >= pend_q.size()); c++) begin
            a0 = acc_cnt;
            step();
            if (acc_cnt != a0) begin
                idx++;
                if (idx < 6) drive(ops[idx]); else in_valid = 1'b0;
            end
            n_cmp++;
            if (in_ready !== (occ < DEPTH)) begin
                n_fail++;
                $display("FAIL full_ready: got in_ready=%b want %b (occupancy %0d)", in_ready, occ < DEPTH, occ);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (idx != 6 || obs_q.size() != 6) begin
            n_fail++;
            $display("FAIL full_complete: accepted %0d completed %0d want 6 6", idx, obs_q.size());
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL full_order: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
    endtask

    task automatic test_wrap();
        rec_t o, e;
        cdb_grant = 1'b1;
        strobe_addr_q.delete();
        offer('{is_store: 1'b0, tag: 4'd9, base: 32'h00000010, off: 32'hFFFFFFFC, data: 32'h0});
        drain();
        offer('{is_store: 1'b0, tag: 4'd10, base: 32'hFFFFFFFC, off: 32'h00000008, data: 32'h0});
        drain();
        n_cmp++;
        if (strobe_addr_q.size() != 2 || strobe_addr_q[0] !== 32'h0000000C || strobe_addr_q[1] !== 32'h00000004) begin
            n_fail++;
            $display("FAIL wrap_addr: got %0d accesses first=%h second=%h want 0000000c 00000004",
                     strobe_addr_q.size(), (strobe_addr_q.size() > 0) ? strobe_addr_q[0] : 32'hx,
                     (strobe_addr_q.size() > 1) ? strobe_addr_q[1] : 32'hx);
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_result: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
    endtask

    task automatic test_random();
        rec_t o, e;
        int   idx, a0;
        idx = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && !(idx == 30 && obs_q.size() >= pend_q.size()); c++) begin
            cdb_grant = ($urandom_range(0, 3) != 0);
            if (!in_valid && idx < 30 && $urandom_range(0, 1) == 1) drive(gen_stim(1'($urandom_range(0, 1))));
            a0 = acc_cnt;
            step();
            if (acc_cnt != a0) begin in_valid = 1'b0; idx++; end
        end
        in_valid = 1'b0;
        cdb_grant = 1'b1;
        n_cmp++;
        if (idx != 30 || obs_q.size() < pend_q.size()) begin
            n_fail++;
            $display("FAIL rand_timeout: accepted %0d of 30, %0d of %0d completed", idx, obs_q.size(), pend_q.size());
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rand_order: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
        n_cmp++;
        if (both_low !== 0) begin
            n_fail++;
            $display("FAIL strobe_exclusive: both strobes low in %0d cycles, want 0", both_low);
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (ram[i] !== ref_ram[i]) begin
                n_fail++;
                $display("FAIL rand_ram[%0d]: got %h want %h", i, ram[i], ref_ram[i]);
            end
        end
    endtask

`ifdef MEM_CHECK_EN
    task automatic test_check();
        rec_t o, e;
        int   s0;
        cdb_grant = 1'b1;
        s0 = strobe_cnt;
        offer('{is_store: 1'b0, tag: 4'd6, base: 32'd2, off: 32'd4, data: 32'h0});
        step();
        n_cmp++;
        if (mem_nRD !== 1'b1 || mem_nWR !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_slot: got nRD=%b nWR=%b want 1 1", mem_nRD, mem_nWR);
        end
        step();
        n_cmp++;
        if (err !== 1'b1 || err_tag !== 4'd6 || cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_err_pulse: got err=%b tag=%h cdb_valid=%b want 1 6 0", err, err_tag, cdb_valid);
        end
        offer('{is_store: 1'b0, tag: 4'd7, base: 32'd60, off: 32'd0, data: 32'h0});
        offer('{is_store: 1'b0, tag: 4'd8, base: 32'd0, off: 32'd0, data: 32'h0});
        drain();
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL chk_strobes: got %0d strobe cycles want 1", strobe_cnt - s0);
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); e = model_retire();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL chk_result: got kind=%0d tag=%h data=%h want kind=%0d tag=%h data=%h",
                         o.kind, o.tag, o.data, e.kind, e.tag, e.data);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int s0;
        cdb_grant = 1'b0;
        offer(gen_stim(1'b0));
        for (int i = 0; i < 3; i++) offer(gen_stim(1'b1));
        for (int i = 0; i < 20 && cdb_valid !== 1'b1; i++) step();
        n_cmp++;
        if (cdb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_bcast: got cdb_valid=%b want 1 before reset", cdb_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend_q.delete();
        occ = 0;
        n_cmp++;
        if ({cdb_valid, in_ready, mem_nRD, mem_nWR} !== 4'b0111) begin
            n_fail++;
            $display("FAIL rm_flush: got cdb_valid=%b in_ready=%b nRD=%b nWR=%b want 0 1 1 1",
                     cdb_valid, in_ready, mem_nRD, mem_nWR);
        end
        s0 = strobe_cnt;
        cdb_grant = 1'b1;
        repeat (15) step();
        n_cmp++;
        if (obs_q.size() != 0 || strobe_cnt != s0) begin
            n_fail++;
            $display("FAIL rm_quiet: got %0d completions and %0d strobe cycles after reset want 0 0",
                     obs_q.size(), strobe_cnt - s0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_tag = '0;
        in_base = '0; in_offset = '0; in_data = '0; cdb_grant = 1'b0;
        cur_op = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 8'($urandom);
            ref_ram[i] = ram[i];
        end
        test_reset();
        test_store_load();
        test_grant_stall();
        test_full();
        test_wrap();
        test_random();
`ifdef MEM_CHECK_EN
        test_check();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
